// File: rtl/add_seq_pkg.sv
// Shared types and constants for the multi-cycle wide add/subtract sequencer.
package add_seq_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 32'sd0;
    while ((32'sd1 << r) < n) r = r + 32'sd1;
    return r;
  endfunction

endpackage

// File: rtl/add_seq_ctrl_if.sv
// Request/result bundle between the ALU front end and add_seq_ctrl.
// Carries the acc request only when ADD_SEQ_CTRL_ACC_EN is defined.
interface add_seq_ctrl_if #(parameter int WORDS = 4);
  import add_seq_pkg::*;

  localparam int W = SLICE_W * WORDS;

  logic         start;
  logic         op_sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
`ifdef ADD_SEQ_CTRL_ACC_EN
  logic         acc;
`endif
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

`ifdef ADD_SEQ_CTRL_ACC_EN
  modport master (output start, op_sub, a, b, acc,
                  input  ready, busy, done, result, carry_out, overflow);
  modport slave  (input  start, op_sub, a, b, acc,
                  output ready, busy, done, result, carry_out, overflow);
`else
  modport master (output start, op_sub, a, b,
                  input  ready, busy, done, result, carry_out, overflow);
  modport slave  (input  start, op_sub, a, b,
                  output ready, busy, done, result, carry_out, overflow);
`endif

endinterface

// File: rtl/add_seq_ctrl_sum_16b.sv
// 16-bit adder slice: four 4-bit lookahead groups with a group-level carry chain.
module sum_16b (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic        G,
  output logic        P,
  output logic [15:0] sum,
  output logic        Cout
);

  logic [15:0] g_s;
  logic [15:0] p_s;
  logic [15:0] c_s;
  logic [3:0]  gg_s;
  logic [3:0]  gp_s;
  logic [4:0]  gc_s;

  // Group generate/propagate, group carries, then bit carries inside each group.
  always_comb begin
    g_s  = a & b;
    p_s  = a ^ b;
    gg_s = 4'b0000;
    gp_s = 4'b0000;
    c_s  = 16'h0000;
    gc_s = 5'b00000;
    for (int j = 0; j < 4; j++) begin
      gg_s[j] = g_s[4*j+3]
              | (p_s[4*j+3] & g_s[4*j+2])
              | (p_s[4*j+3] & p_s[4*j+2] & g_s[4*j+1])
              | (p_s[4*j+3] & p_s[4*j+2] & p_s[4*j+1] & g_s[4*j]);
      gp_s[j] = &p_s[4*j +: 4];
    end
    gc_s[0] = c_in;
    for (int j = 0; j < 4; j++) begin
      gc_s[j+1] = gg_s[j] | (gp_s[j] & gc_s[j]);
    end
    for (int j = 0; j < 4; j++) begin
      c_s[4*j] = gc_s[j];
      for (int i = 0; i < 3; i++) begin
        c_s[4*j+i+1] = g_s[4*j+i] | (p_s[4*j+i] & c_s[4*j+i]);
      end
    end
    sum  = p_s ^ c_s;
    Cout = gc_s[4];
    G    = gg_s[3] | (gp_s[3] & gg_s[2]) | (gp_s[3] & gp_s[2] & gg_s[1])
         | (gp_s[3] & gp_s[2] & gp_s[1] & gg_s[0]);
    P    = &gp_s;
  end

endmodule

// File: rtl/add_seq_ctrl.sv
// Wide add/subtract sequencer reusing one 16-bit slice, LSB beat first.
// Optional accumulate mode (A <- current result) enabled by ADD_SEQ_CTRL_ACC_EN.
module add_seq_ctrl
  import add_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  add_seq_ctrl_if.slave bus
);

  localparam int W  = SLICE_W * WORDS;
  localparam int BW = clog2(WORDS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(WORDS - 1);

  state_t               state_r;
  logic [BW-1:0]        beat_r;
  logic                 carry_r;
  logic                 op_sub_r;
  logic [W-1:0]         a_r;
  logic [W-1:0]         b_r;
  logic [W-1:0]         result_r;
  logic                 ready_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 carry_out_r;
  logic                 overflow_r;

  logic [BW+3:0]        base_s;
  logic [SLICE_W-1:0]   slice_a_s;
  logic [SLICE_W-1:0]   slice_b_s;
  logic [SLICE_W-1:0]   sum_s;
  logic                 cin_s;
  logic                 cout_s;
  logic                 ov_s;
  logic [W-1:0]         a_sel_s;
  logic                 slice_g_unused;
  logic                 slice_p_unused;

  // Steer the current beat into the slice and form the final-beat overflow.
  always_comb begin
    base_s    = {beat_r, 4'b0000};
    slice_a_s = a_r[base_s +: SLICE_W];
    slice_b_s = b_r[base_s +: SLICE_W] ^ {SLICE_W{op_sub_r}};
    if (beat_r == {BW{1'b0}}) begin
      cin_s = op_sub_r;
    end else begin
      cin_s = carry_r;
    end
    ov_s = (a_r[W-1] == (b_r[W-1] ^ op_sub_r)) && (sum_s[SLICE_W-1] != a_r[W-1]);
`ifdef ADD_SEQ_CTRL_ACC_EN
    if (bus.acc) begin
      a_sel_s = result_r;
    end else begin
      a_sel_s = bus.a;
    end
`else
    a_sel_s = bus.a;
`endif
  end

  sum_16b u_slice (
    .a    (slice_a_s),
    .b    (slice_b_s),
    .c_in (cin_s),
    .G    (slice_g_unused),
    .P    (slice_p_unused),
    .sum  (sum_s),
    .Cout (cout_s)
  );

  // Sequencer FSM: operand capture, per-beat writeback and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      beat_r      <= {BW{1'b0}};
      carry_r     <= 1'b0;
      op_sub_r    <= 1'b0;
      a_r         <= {W{1'b0}};
      b_r         <= {W{1'b0}};
      result_r    <= {W{1'b0}};
      ready_r     <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      carry_out_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          result_r[base_s +: SLICE_W] <= sum_s;
          carry_r <= cout_s;
          if (beat_r == LAST_BEAT) begin
            state_r     <= ST_DONE;
            beat_r      <= {BW{1'b0}};
            ready_r     <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
            carry_out_r <= cout_s;
            overflow_r  <= ov_s;
          end else begin
            beat_r <= beat_r + {{(BW-1){1'b0}}, 1'b1};
          end
        end
        ST_IDLE, ST_DONE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            state_r  <= ST_RUN;
            beat_r   <= {BW{1'b0}};
            carry_r  <= 1'b0;
            op_sub_r <= bus.op_sub;
            a_r      <= a_sel_s;
            b_r      <= bus.b;
            ready_r  <= 1'b0;
            busy_r   <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          beat_r  <= {BW{1'b0}};
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready     = ready_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.result    = result_r;
  assign bus.carry_out = carry_out_r;
  assign bus.overflow  = overflow_r;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Randomized self-checking bench for add_seq_ctrl against a plain-arithmetic model.
module tb_add_seq_ctrl;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  logic [W-1:0] model_res;

  always #5 clk = ~clk;

  add_seq_ctrl_if #(.WORDS(WORDS)) bus ();

  add_seq_ctrl #(.WORDS(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  function automatic void model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic op,
                                output logic [W-1:0] r, output logic co, output logic ov);
    logic signed [W+1:0] sa, sb, s;
    logic [W:0] us;
    sa = {{2{av[W-1]}}, av};
    sb = {{2{bv[W-1]}}, bv};
    s  = op ? sa - sb : sa + sb;
    r  = s[W-1:0];
    ov = (s[W+1:W-1] != {3{s[W-1]}});
    us = {1'b0, av} + {1'b0, bv};
    co = op ? (av >= bv) : us[W];
  endfunction

  function automatic logic [W-1:0] rand_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0: v = '1;
      1: v = {1'b0, {(W-1){1'b1}}};
      2: v = {1'b1, {(W-1){1'b0}}};
      3: v = W'($urandom_range(0, 3));
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic op,
                        input logic accv, output logic [W-1:0] r, output logic co,
                        output logic ov, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    bus.start  = 1'b1;
    bus.a      = av;
    bus.b      = bv;
    bus.op_sub = op;
`ifdef ADD_SEQ_CTRL_ACC_EN
    bus.acc    = accv;
`endif
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.a      = {$urandom, $urandom};
    bus.b      = {$urandom, $urandom};
    bus.op_sub = 1'($urandom);
    lat = 0;
    while (!bus.done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    r  = bus.result;
    co = bus.carry_out;
    ov = bus.overflow;
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.result !== '0 || bus.carry_out !== 1'b0 || bus.overflow !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: rdy=%b busy=%b done=%b res=%h co=%b ov=%b expected 1 0 0 0 0 0",
               bus.ready, bus.busy, bus.done, bus.result, bus.carry_out, bus.overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_res = '0;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta[4], tb[4], tr[4];
    logic         top[4], tco[4], tov[4];
    logic [W-1:0] r;
    logic         co, ov;
    int           lat;
    ta[0] = 64'h0000_0000_0000_FFFF; tb[0] = 64'h1; top[0] = 1'b0;
    tr[0] = 64'h0000_0000_0001_0000; tco[0] = 1'b0; tov[0] = 1'b0;
    ta[1] = 64'hFFFF_FFFF_FFFF_FFFF; tb[1] = 64'h1; top[1] = 1'b0;
    tr[1] = 64'h0;                   tco[1] = 1'b1; tov[1] = 1'b0;
    ta[2] = 64'h7FFF_FFFF_FFFF_FFFF; tb[2] = 64'h1; top[2] = 1'b0;
    tr[2] = 64'h8000_0000_0000_0000; tco[2] = 1'b0; tov[2] = 1'b1;
    ta[3] = 64'h0;                   tb[3] = 64'h1; top[3] = 1'b1;
    tr[3] = 64'hFFFF_FFFF_FFFF_FFFF; tco[3] = 1'b0; tov[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      run_op(ta[i], tb[i], top[i], 1'b0, r, co, ov, lat);
      model_res = tr[i];
      tests++;
      if (lat !== WORDS || r !== tr[i] || co !== tco[i] || ov !== tov[i]) begin
        fails++;
        $display("FAIL directed_%0d: lat=%0d res=%h co=%b ov=%b expected lat=%0d res=%h co=%b ov=%b",
                 i, lat, r, co, ov, WORDS, tr[i], tco[i], tov[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] av, bv, r, er, aeff;
    logic         op, accv, co, ov, eco, eov;
    int           lat;
    for (int i = 0; i < 40; i++) begin
      av = rand_operand();
      bv = rand_operand();
      op = 1'($urandom);
`ifdef ADD_SEQ_CTRL_ACC_EN
      accv = ($urandom_range(0, 3) == 0);
`else
      accv = 1'b0;
`endif
      aeff = accv ? model_res : av;
      model(aeff, bv, op, er, eco, eov);
      run_op(av, bv, op, accv, r, co, ov, lat);
      model_res = er;
      tests++;
      if (lat !== WORDS || r !== er || co !== eco || ov !== eov) begin
        fails++;
        $display("FAIL random_%0d: a=%h b=%h sub=%b acc=%b lat=%0d res=%h co=%b ov=%b expected res=%h co=%b ov=%b",
                 i, aeff, bv, op, accv, lat, r, co, ov, er, eco, eov);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] av, bv, er;
    logic         eco, eov;
    int           lat;
    av = {$urandom, $urandom};
    bv = {$urandom, $urandom};
    model(av, bv, 1'b0, er, eco, eov);
    @(negedge clk);
    bus.start = 1'b1; bus.a = av; bus.b = bv; bus.op_sub = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.a = ~av; bus.b = 64'h1234; bus.op_sub = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    tests++;
    if (bus.busy !== 1'b1 || bus.ready !== 1'b0) begin
      fails++;
      $display("FAIL ignore_start_busy: busy=%b ready=%b expected 1 0", bus.busy, bus.ready);
    end
    lat = 2;
    while (!bus.done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    model_res = er;
    tests++;
    if (lat !== WORDS || bus.result !== er || bus.carry_out !== eco) begin
      fails++;
      $display("FAIL ignore_start_result: lat=%0d res=%h co=%b expected lat=%0d res=%h co=%b",
               lat, bus.result, bus.carry_out, WORDS, er, eco);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] r, er2, er1, av2, bv2;
    logic         co, ov, eco, eov;
    int           lat;
    model(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b1, er1, eco, eov);
    run_op(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b1, 1'b0, r, co, ov, lat);
    tests++;
    if (r !== er1 || lat !== WORDS) begin
      fails++;
      $display("FAIL b2b_first: res=%h lat=%0d expected %h %0d", r, lat, er1, WORDS);
    end
    av2 = {$urandom, $urandom};
    bv2 = {$urandom, $urandom};
    model(av2, bv2, 1'b0, er2, eco, eov);
    @(negedge clk);
    bus.start = 1'b1; bus.a = av2; bus.b = bv2; bus.op_sub = 1'b0;
`ifdef ADD_SEQ_CTRL_ACC_EN
    bus.acc = 1'b0;
`endif
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    tests++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      fails++;
      $display("FAIL b2b_accept: busy=%b done=%b expected 1 0", bus.busy, bus.done);
    end
    lat = 0;
    while (!bus.done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    model_res = er2;
    tests++;
    if (lat !== WORDS || bus.result !== er2 || bus.carry_out !== eco || bus.overflow !== eov) begin
      fails++;
      $display("FAIL b2b_second: lat=%0d res=%h co=%b ov=%b expected %0d %h %b %b",
               lat, bus.result, bus.carry_out, bus.overflow, WORDS, er2, eco, eov);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] r, er;
    logic         co, ov, eco, eov;
    int           lat, seen;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 64'hFFFF_FFFF_FFFF_FFFF; bus.b = 64'h1; bus.op_sub = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_res = '0;
    tests++;
    if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.result !== '0 || bus.done !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_run: rdy=%b busy=%b res=%h done=%b expected 1 0 0 0",
               bus.ready, bus.busy, bus.result, bus.done);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < WORDS + 3; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) seen++;
    end
    tests++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL reset_no_done: done pulses=%0d expected 0", seen);
    end
    model(64'h0000_0000_1234_5678, 64'h0000_0000_0000_0008, 1'b0, er, eco, eov);
    run_op(64'h0000_0000_1234_5678, 64'h0000_0000_0000_0008, 1'b0, 1'b0, r, co, ov, lat);
    model_res = er;
    tests++;
    if (lat !== WORDS || r !== er || co !== eco) begin
      fails++;
      $display("FAIL reset_recover: lat=%0d res=%h co=%b expected %0d %h %b", lat, r, co, WORDS, er, eco);
    end
  endtask

`ifdef ADD_SEQ_CTRL_ACC_EN
  task automatic test_acc();
    logic [W-1:0] r, ea[4], eb[4], er[4];
    logic         eo[4], ec[4], co, ov;
    int           lat;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ea[0] = 64'hDEAD; eb[0] = 64'd7;  eo[0] = 1'b0; ec[0] = 1'b1; er[0] = 64'd7;
    ea[1] = 64'd5;    eb[1] = 64'd3;  eo[1] = 1'b0; ec[1] = 1'b0; er[1] = 64'd8;
    ea[2] = 64'h99;   eb[2] = 64'd10; eo[2] = 1'b0; ec[2] = 1'b1; er[2] = 64'd18;
    ea[3] = 64'h77;   eb[3] = 64'd20; eo[3] = 1'b1; ec[3] = 1'b1; er[3] = 64'hFFFF_FFFF_FFFF_FFFE;
    for (int i = 0; i < 4; i++) begin
      run_op(ea[i], eb[i], eo[i], ec[i], r, co, ov, lat);
      tests++;
      if (lat !== WORDS || r !== er[i]) begin
        fails++;
        $display("FAIL acc_%0d: lat=%0d res=%h expected %0d %h", i, lat, r, WORDS, er[i]);
      end
    end
    model_res = er[3];
  endtask
`endif

  initial begin
    bus.start  = 1'b0;
    bus.op_sub = 1'b0;
    bus.a      = '0;
    bus.b      = '0;
`ifdef ADD_SEQ_CTRL_ACC_EN
    bus.acc    = 1'b0;
`endif
    model_res  = '0;
    repeat (3) @(posedge clk);
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_random();
    test_reset_mid_run();
`ifdef ADD_SEQ_CTRL_ACC_EN
    test_acc();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/add_seq_ctrl.md
Name: add_seq_ctrl

Overview:
Multi-cycle sequencer that performs wide add/subtract (16*WORDS bits) by reusing one 16-bit group-lookahead adder slice, one 16-bit beat per clock.
- Latches operands on a start handshake.
- Steers the slice inputs beat by beat, LSB beat first.
- Ripples carry between beats through a register.
- Reports result, carry, and signed overflow with a done pulse.
- Sits between a register-file/ALU front end and the shared 16-bit adder datapath.

Parameters:
WORDS, 4, number of 16-bit beats per operation (legal 2..8); operand width W = 16*WORDS.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; accepted only when ready=1.
op_sub  input  1  0 = A+B, 1 = A-B; sampled with start.
a  input  W  operand A; sampled with start.
b  input  W  operand B; sampled with start.
ready  output  1  high in IDLE and DONE.
busy  output  1  high in RUN.
done  output  1  one-cycle pulse when result is valid.
result  output  W  sum/difference, held until next accepted start.
carry_out  output  1  carry out of the top beat; for subtract, 1 means no borrow.
overflow  output  1  signed two's-complement overflow of the W-bit operation.

Behaviour:
- One clock, clk. Reset is asynchronous, active-low on rst_n.
- Reset (any time, including mid-RUN):
  - state=IDLE, beat counter=0, carry register=0.
  - result=0, carry_out=0, overflow=0, done=0.
  - In-flight operation is discarded.
- FSM transitions:
  - IDLE -> RUN on start.
  - RUN -> RUN while beat < WORDS-1.
  - RUN -> DONE after beat WORDS-1.
  - DONE -> RUN on start; otherwise DONE -> IDLE.
- DONE lasts exactly one cycle; done=1 only in DONE.
- Start rules:
  - Start in DONE is accepted back-to-back.
  - Start while busy is ignored: no queueing, operands not resampled.
- Beat k, k = 0..WORDS-1:
  - Slice a = A[16k+15:16k].
  - Slice b = B[16k+15:16k] XOR {16{op_sub}}.
  - Slice c_in = op_sub when k=0, else the carry register.
  - At the clock edge, the slice sum is written to result[16k+15:16k] and slice Cout to the carry register.
- Latency: start accepted at edge N -> done=1 during cycle N+WORDS+1, i.e. WORDS RUN cycles plus 1 DONE cycle.
- result bits are updated progressively during RUN. Consumers must sample only when done=1.
- carry_out and overflow update at the final beat's edge and are valid with done.
- overflow = (A[W-1] == Beff[W-1]) && (result[W-1] != A[W-1]), where Beff is the inverted B for subtract.
- Operands are captured into internal registers at accept. Input changes during RUN have no effect.
- Slice G/P outputs are unused; the carry between beats uses Cout only.
- Wrap-around: all W-bit arithmetic is modulo 2^W. The carry register is cleared at accept.

Optional Feature:
Macro ADD_SEQ_CTRL_ACC_EN.
- Defined:
  - Extra input acc (1 bit), sampled with start.
  - acc=1 replaces operand A with the current result register, giving accumulate / running subtract.
  - acc=1 after reset uses A=0.
- Undefined:
  - Port acc is absent.
  - A always comes from port a.

Decomposition:
- Shared package/include add_seq_pkg:
  - FSM state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Beat width constant SLICE_W=16.
  - Beat counter width function clog2(WORDS).
- One sub-module, natural and already existing: the 16-bit group-lookahead adder slice (sum_16b: a, b, c_in, G, P, sum, Cout). It is instantiated once; the controller contains only registers, mux steering and the FSM.

Test Plan:
1. WORDS=4, A=64'h0000_0000_0000_FFFF, B=64'h1, add -> result=64'h0000_0000_0001_0000, carry_out=0, overflow=0; done exactly 5 cycles after the accepted start.
2. A=64'hFFFF_FFFF_FFFF_FFFF, B=64'h1, add -> result=0, carry_out=1, overflow=0 (carry ripples through all 4 beats).
3. A=64'h7FFF_FFFF_FFFF_FFFF, B=64'h1, add -> result=64'h8000_0000_0000_0000, overflow=1. Then A=64'h0, B=64'h1, sub -> result=64'hFFFF_FFFF_FFFF_FFFF, carry_out=0, overflow=0.
4. Start pulsed with new operands during RUN -> ignored; first result unchanged. Start held high in DONE -> second op accepted with no IDLE cycle.
5. rst_n low at RUN beat 2 -> immediately ready=1, busy=0, result=0, done never pulses. A new start after release completes normally.
6. ADD_SEQ_CTRL_ACC_EN defined: start A=5, B=3 add -> 8. Then acc=1, B=10 -> 18. Then acc=1, B=20, sub -> 64'hFFFF_FFFF_FFFF_FFFE.
